// File: rtl/wb_stage_pipe.sv
// Registered write-back stage: source select, one-cycle RF write, flush, sticky halt, retire counter.
// Optional post-write forwarding hold register enabled by defining WB_FWD_EN.
module wb_stage_pipe #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned REG_AW  = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic [NUM_SRC*DATA_W-1:0]   in_src,
    input  logic                        in_wr_en,
    input  logic [REG_AW-1:0]           in_wr_addr,
    input  logic                        in_halt,
    input  logic                        flush,
    output logic                        rf_wr_en,
    output logic [REG_AW-1:0]           rf_wr_addr,
    output logic [DATA_W-1:0]           rf_wr_data,
    output logic                        halted,
    output logic [CNT_W-1:0]            retired,
    output logic                        fwd_valid,
    output logic [REG_AW-1:0]           fwd_addr,
    output logic [DATA_W-1:0]           fwd_data
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t              state;
    logic                stage_valid;
    logic                stage_halt;
    logic                accept;
    logic [DATA_W-1:0]   sel_data;

    // Unpopulated select codes resolve to zero data.
    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_src[k*DATA_W +: DATA_W];
            end
        end
    end

    assign in_ready = (state == ST_RUN);
    assign halted   = (state == ST_HALTED);
    assign accept   = in_valid & in_ready & ~flush;

    // Halt takes effect once the latched HALT has retired.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:    if (stage_valid && stage_halt) state <= ST_HALTED;
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_RUN;
            endcase
        end
    end

    // Stage register; the RF port is the write-qualified view of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_halt  <= 1'b0;
            rf_wr_en    <= 1'b0;
            rf_wr_addr  <= '0;
            rf_wr_data  <= '0;
        end else begin
            stage_valid <= accept;
            stage_halt  <= accept & in_halt;
            rf_wr_en    <= accept & in_wr_en;
            if (accept && in_wr_en) begin
                rf_wr_addr <= in_wr_addr;
                rf_wr_data <= sel_data;
            end
        end
    end

    // Saturating retire counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (stage_valid && (retired != {CNT_W{1'b1}})) begin
            retired <= retired + CNT_W'(1);
        end
    end

`ifdef WB_FWD_EN
    // Holds last cycle's write for register files lacking write-through bypass.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else begin
            fwd_valid <= rf_wr_en;
            fwd_addr  <= rf_wr_addr;
            fwd_data  <= rf_wr_data;
        end
    end
`else
    assign fwd_valid = 1'b0;
    assign fwd_addr  = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Randomized bench for wb_stage_pipe: a default instance and a 3-source, 4-bit-counter instance
// share stimulus and are each compared every cycle against a cycle-level reference model.
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_sel;
    logic [15:0] src [4];
    logic        in_wr_en;
    logic [2:0]  in_wr_addr;
    logic        in_halt;
    logic        flush;

    logic        o_ready [2];
    logic        o_wen   [2];
    logic [2:0]  o_addr  [2];
    logic [15:0] o_data  [2];
    logic        o_halted[2];
    logic [15:0] o_ret   [2];
    logic        o_fv    [2];
    logic [2:0]  o_fa    [2];
    logic [15:0] o_fd    [2];
    logic [3:0]  sat_ret;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_stage_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_ready[0]),
        .in_sel(in_sel), .in_src({src[3], src[2], src[1], src[0]}),
        .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_halt(in_halt), .flush(flush),
        .rf_wr_en(o_wen[0]), .rf_wr_addr(o_addr[0]), .rf_wr_data(o_data[0]),
        .halted(o_halted[0]), .retired(o_ret[0]),
        .fwd_valid(o_fv[0]), .fwd_addr(o_fa[0]), .fwd_data(o_fd[0])
    );

    wb_stage_pipe #(.NUM_SRC(3), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_ready[1]),
        .in_sel(in_sel), .in_src({src[2], src[1], src[0]}),
        .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_halt(in_halt), .flush(flush),
        .rf_wr_en(o_wen[1]), .rf_wr_addr(o_addr[1]), .rf_wr_data(o_data[1]),
        .halted(o_halted[1]), .retired(sat_ret),
        .fwd_valid(o_fv[1]), .fwd_addr(o_fa[1]), .fwd_data(o_fd[1])
    );
    assign o_ret[1] = 16'(sat_ret);

    // Reference model state, one slot per instance.
    int unsigned nsrc [2] = '{4, 3};
    int unsigned cmax [2] = '{65535, 15};
    bit          m_pv [2];
    bit          m_ph [2];
    bit          m_halted [2];
    int unsigned m_ret [2];
    bit          m_wen [2];
    int unsigned m_addr [2];
    int unsigned m_data [2];
    bit          m_fv [2];
    int unsigned m_fa [2];
    int unsigned m_fd [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // One clock edge of the architectural behaviour, from the pre-edge inputs.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit take;
            if (!rst_n) begin
                m_pv[i] = 0; m_ph[i] = 0; m_halted[i] = 0; m_ret[i] = 0;
                m_wen[i] = 0; m_addr[i] = 0; m_data[i] = 0;
                m_fv[i] = 0; m_fa[i] = 0; m_fd[i] = 0;
            end else begin
                m_fv[i] = m_wen[i]; m_fa[i] = m_addr[i]; m_fd[i] = m_data[i];
                if (m_pv[i] && m_ret[i] < cmax[i]) m_ret[i] = m_ret[i] + 1;
                take = in_valid && !m_halted[i] && !flush;
                if (m_pv[i] && m_ph[i]) m_halted[i] = 1;
                m_pv[i]  = take;
                m_ph[i]  = take && in_halt;
                m_wen[i] = take && in_wr_en;
                if (m_wen[i]) begin
                    m_addr[i] = in_wr_addr;
                    m_data[i] = (in_sel < nsrc[i]) ? int'(src[in_sel]) : 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            string n = (i == 0) ? "dut" : "sat";
            chk({n, ".rf_wr_en"},   32'(o_wen[i]),    32'(m_wen[i]));
            chk({n, ".rf_wr_addr"}, 32'(o_addr[i]),   m_addr[i]);
            chk({n, ".rf_wr_data"}, 32'(o_data[i]),   m_data[i]);
            chk({n, ".halted"},     32'(o_halted[i]), 32'(m_halted[i]));
            chk({n, ".in_ready"},   32'(o_ready[i]),  32'(!m_halted[i]));
            chk({n, ".retired"},    32'(o_ret[i]),    m_ret[i]);
`ifdef WB_FWD_EN
            chk({n, ".fwd_valid"},  32'(o_fv[i]), 32'(m_fv[i]));
            chk({n, ".fwd_addr"},   32'(o_fa[i]), m_fa[i]);
            chk({n, ".fwd_data"},   32'(o_fd[i]), m_fd[i]);
`else
            chk({n, ".fwd_valid"},  32'(o_fv[i]), 32'd0);
            chk({n, ".fwd_addr"},   32'(o_fa[i]), 32'd0);
            chk({n, ".fwd_data"},   32'(o_fd[i]), 32'd0);
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit v, input bit f, input logic [1:0] s,
                         input bit we, input logic [2:0] a, input bit h);
        in_valid = v; flush = f; in_sel = s; in_wr_en = we; in_wr_addr = a; in_halt = h;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        src[0] = 16'h1111; src[1] = 16'h2222; src[2] = 16'h3333; src[3] = 16'h4444;
        drive(0, 0, 0, 0, 0, 0);
        do_reset();
        chk("reset.in_ready", 32'(o_ready[0]), 32'd1);
        chk("reset.retired",  32'(o_ret[0]),   32'd0);

        // Every source select, back to back, to address 5.
        for (int s = 0; s < 4; s++) begin
            drive(1, 0, 2'(s), 1, 3'd5, 0);
            step();
            chk($sformatf("sel%0d.data", s), 32'(o_data[0]), 32'(16'h1111 * (s + 1)));
            chk($sformatf("sel%0d.addr", s), 32'(o_addr[0]), 32'd5);
        end
        chk("sel3.sat_zero", 32'(o_data[1]), 32'd0);

        // Flush behind a pending write: the pending write completes, the flushed one does not.
        drive(1, 0, 2'd1, 1, 3'd4, 0);
        step();
        drive(1, 1, 2'd2, 1, 3'd2, 0);
        step();
        chk("flush.prior_addr", 32'(o_addr[0]), 32'd4);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("flush.no_write", 32'(o_wen[0]), 32'd0);

        // Forwarding of R3 = 0xA5A5.
        src[0] = 16'hA5A5;
        drive(1, 0, 2'd0, 1, 3'd3, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
`ifdef WB_FWD_EN
        chk("fwd.data", 32'(o_fd[0]), 32'h0000A5A5);
        chk("fwd.addr", 32'(o_fa[0]), 32'd3);
`else
        chk("fwd.tied", 32'(o_fd[0]), 32'd0);
`endif

        // Randomized traffic with occasional flush and reset.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 4; k++) src[k] = 16'($urandom);
            rst_n = ($urandom_range(0, 49) != 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  3'($urandom_range(0, 7)), 0);
            step();
        end
        rst_n = 1'b1;

        // Counter saturation on the 4-bit instance.
        do_reset();
        for (int n = 0; n < 20; n++) begin
            drive(1, 0, 2'($urandom_range(0, 3)), 1, 3'($urandom_range(0, 7)), 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("sat.retired15", 32'(o_ret[1]), 32'd15);
        chk("dut.retired20", 32'(o_ret[0]), 32'd20);

        // HALT writing R7 = 0xBEEF, then ignored traffic.
        src[2] = 16'hBEEF;
        drive(1, 0, 2'd2, 1, 3'd7, 1);
        step();
        chk("halt.wen",  32'(o_wen[0]),  32'd1);
        chk("halt.data", 32'(o_data[0]), 32'h0000BEEF);
        chk("halt.addr", 32'(o_addr[0]), 32'd7);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("halt.halted",   32'(o_halted[0]), 32'd1);
        chk("halt.in_ready", 32'(o_ready[0]),  32'd0);
        for (int n = 0; n < 10; n++) begin
            drive(1, 0, 2'($urandom_range(0, 3)), 1, 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
            step();
            chk("halt.ignored", 32'(o_wen[0]), 32'd0);
        end

        // Reset while an instruction is latched drops it.
        do_reset();
        drive(1, 0, 2'd1, 1, 3'd6, 0);
        @(posedge clk);
        model_edge();
        rst_n = 1'b0;
        #1;
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("rstdrop.wen",     32'(o_wen[0]), 32'd0);
        chk("rstdrop.retired", 32'(o_ret[0]), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rstdrop.after", 32'(o_ret[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
